// File: rtl/debug_unit_loader.sv
// debug_unit_loader: loads instruction memory from UART bytes (LSB-first words) and
// gates the MIPS clock enable in continuous or single-step mode after a HALT word.
module debug_unit_loader #(
  parameter int LEN = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK100MHZ,
  input  logic                  SWITCH_RESET,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  halt_in,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [LEN-1:0]        imem_data,
  output logic                  mips_clk_en,
  output logic                  mips_reset,
  output logic                  run_done,
  output logic [2:0]            state_out
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PROG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_STEP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [LEN-1:0]        word_q, word_d, data_q, data_d, full;
  logic                  wr_en_q, wr_en_d, clk_en_q, clk_en_d, mreset_q, mreset_d, done_q, done_d, step;
  assign full = {rx_data, word_q[LEN-9:0]};
  always_comb begin
    state_d = state_q;
    addr_d  = wr_en_q ? addr_q + 1'b1 : addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: state_d = (rx_done && rx_data == 8'h01) ? S_PROG : S_IDLE;
      S_PROG: if (rx_done) begin
        if (cnt_q == 2'd3) begin
          wr_en_d = 1'b1;
          data_d  = full;
          cnt_d   = 2'd0;
          word_d  = '0;
          state_d = (full[LEN-1:LEN-6] == 6'b111111) ? S_WAIT : S_PROG;
        end else begin
          word_d[{cnt_q, 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WAIT: if (rx_done)
        state_d = rx_data == 8'h02 ? S_RUN : rx_data == 8'h03 ? S_STEP : rx_data == 8'h05 ? S_IDLE : S_WAIT;
      S_RUN:  state_d = halt_in ? S_DONE : S_RUN;
      // halt takes priority over a step request arriving in the same cycle
      S_STEP: if (halt_in) state_d = S_DONE;
        else if (rx_done) begin
          step    = rx_data == 8'h06;
          state_d = rx_data == 8'h05 ? S_IDLE : S_STEP;
        end
      S_DONE: state_d = (rx_done && rx_data == 8'h05) ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      addr_d = '0;
      cnt_d  = '0;
      word_d = '0;
    end
    clk_en_d = (state_d == S_RUN) || step;
    mreset_d = state_d <= S_WAIT;
    done_d   = state_d == S_DONE;
  end
  always_ff @(posedge CLK100MHZ) begin
    if (SWITCH_RESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      clk_en_q <= 1'b0;
      mreset_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      clk_en_q <= clk_en_d;
      mreset_q <= mreset_d;
      done_q   <= done_d;
    end
  end
  assign imem_wr_en  = wr_en_q;
  assign imem_addr   = addr_q;
  assign imem_data   = data_q;
  assign mips_clk_en = clk_en_q;
  assign mips_reset  = mreset_q;
  assign run_done    = done_q;
  assign state_out   = state_q;
endmodule

// File: tb/tb_debug_unit_loader.sv
// tb_debug_unit_loader: random + directed stimulus, protocol-level reference model,
// per-cycle status scoreboard and a write scoreboard popped on imem_wr_en.
module tb_debug_unit_loader;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, rst = 1'b1, rx_done = 1'b0, halt_in = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic imem_wr_en, mips_clk_en, mips_reset, run_done;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_data;
  logic [2:0] state_out;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic wr;
    logic [AW-1:0] addr;
    logic ce, mr, rd;
    logic [2:0] st;
  } status_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0] data;
  } wr_t;
  status_t stq[$];
  wr_t wq[$];
  int ms = 0, maddr = 0;
  bit pend = 0;
  logic [7:0] mbytes[$];

  debug_unit_loader #(.LEN(32), .ADDR_WIDTH(AW)) dut (
    .CLK100MHZ(clk), .SWITCH_RESET(rst), .rx_data(rx_data), .rx_done(rx_done),
    .halt_in(halt_in), .imem_wr_en(imem_wr_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .mips_clk_en(mips_clk_en), .mips_reset(mips_reset),
    .run_done(run_done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Reference model: applies the protocol rules to the inputs of this cycle and
  // records what every output should look like in the following cycle.
  task automatic tick();
    status_t s;
    bit wr = 0, stp = 0;
    logic [31:0] w;
    if (rst) begin
      ms = 0;
      maddr = 0;
      pend = 0;
      mbytes.delete();
    end else begin
      if (pend) maddr = (maddr + 1) % DEPTH;
      pend = 0;
      if (ms == 0) begin
        if (rx_done && rx_data == 8'h01) ms = 1;
      end else if (ms == 1) begin
        if (rx_done) begin
          mbytes.push_back(rx_data);
          if (mbytes.size() == 4) begin
            w = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
            wq.push_back('{addr: AW'(maddr), data: w});
            wr = 1;
            pend = 1;
            mbytes.delete();
            if (w[31:26] == 6'h3f) ms = 2;
          end
        end
      end else if (ms == 2) begin
        if (rx_done) ms = rx_data == 8'h02 ? 3 : rx_data == 8'h03 ? 4 : rx_data == 8'h05 ? 0 : 2;
      end else if (ms == 3) begin
        if (halt_in) ms = 5;
      end else if (ms == 4) begin
        if (halt_in) ms = 5;
        else if (rx_done && rx_data == 8'h06) stp = 1;
        else if (rx_done && rx_data == 8'h05) ms = 0;
      end else if (rx_done && rx_data == 8'h05) ms = 0;
      if (ms == 0) begin
        maddr = 0;
        pend = 0;
        mbytes.delete();
      end
    end
    s.wr = wr;
    s.addr = AW'(maddr);
    s.ce = (ms == 3) || stp;
    s.mr = ms <= 2;
    s.rd = ms == 5;
    s.st = 3'(ms);
    stq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    status_t e;
    status_t a;
    wr_t x;
    if (stq.size() > 0) begin
      e = stq.pop_front();
      a = {imem_wr_en, imem_addr, mips_clk_en, mips_reset, run_done, state_out};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL status t=%0t got wr=%b addr=%0d ce=%b mr=%b rd=%b st=%0d want wr=%b addr=%0d ce=%b mr=%b rd=%b st=%0d",
                 $time, a.wr, a.addr, a.ce, a.mr, a.rd, a.st, e.wr, e.addr, e.ce, e.mr, e.rd, e.st);
      end
    end
    if (imem_wr_en === 1'b1) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected t=%0t got addr=%0d data=%h want no write", $time, imem_addr, imem_data);
      end else begin
        x = wq.pop_front();
        if (imem_addr !== x.addr || imem_data !== x.data) begin
          n_fail++;
          $display("FAIL write t=%0t got addr=%0d data=%h want addr=%0d data=%h",
                   $time, imem_addr, imem_data, x.addr, x.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic halt_pulse();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send(v[7:0]);
      v = v >> 8;
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[26] = 1'b0;
    return w;
  endfunction

  function automatic logic [7:0] rand_byte();
    int k;
    k = $urandom_range(0, 7);
    return k == 0 ? 8'h01 : k == 1 ? 8'h02 : k == 2 ? 8'h03 : k == 3 ? 8'h05 : k == 4 ? 8'h06 : 8'($urandom);
  endfunction

  initial begin
    do_reset();
    n_chk++;
    if (imem_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 00000000", imem_data);
    end
    halt_pulse();
    send(8'h07);
    send(8'h01);
    send_word(32'h20080024);
    idle(2);
    send_word(32'h05060201);
    idle(2);
    // reset mid-word: the two early bytes must not leak into the next word
    do_reset();
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    do_reset();
    send(8'h01);
    send_word(32'h11223344);
    idle(2);
    do_reset();
    send(8'h01);
    send_word(rand_word());
    send_word(rand_word());
    send_word(32'hFC000000);
    halt_pulse();
    send(8'h09);
    send(8'h02);
    idle(4);
    send(8'h06);
    halt_pulse();
    idle(2);
    halt_pulse();
    send(8'h05);
    idle(2);
    send(8'h01);
    send_word(rand_word());
    send_word(32'hFC000000);
    send(8'h03);
    idle(2);
    send(8'h06);
    send(8'h06);
    idle(1);
    send(8'h06);
    idle(2);
    halt_in = 1'b1;
    send(8'h06);
    halt_in = 1'b0;
    send(8'h06);
    send(8'h02);
    send(8'h05);
    idle(2);
    send(8'h01);
    for (int i = 0; i < 5; i++) send_word(rand_word());
    idle(2);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 5) send(rand_byte());
      else if (r == 6) halt_pulse();
      else if (r == 7) begin
        halt_in = 1'b1;
        send(rand_byte());
        halt_in = 1'b0;
      end else if (r == 8) send_word(rand_word());
      else if (r == 9) send_word(32'hFC000000 | ($urandom & 32'h03FFFFFF));
      else if (r == 10) idle($urandom_range(1, 3));
      else if ($urandom_range(0, 3) == 0) do_reset();
      else send(8'h01);
    end
    idle(3);
    #20;
    n_chk++;
    if (wq.size() != 0 || stq.size() != 0) begin
      n_fail++;
      $display("FAIL drain got writes_left=%0d status_left=%0d want 0 0", wq.size(), stq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_unit_loader.md
# debug_unit_loader

FPGA-side responder for the host debug protocol. It consumes bytes from the UART receiver, loads the instruction memory with 32-bit words sent LSB-first, and detects the HALT word. It then gates the MIPS pipeline clock enable in continuous or step-by-step mode. It sits between the UART RX and the MIPS core/instruction memory in `top_modular`.

## Interface
- `LEN`, 32, instruction word width; must be 32.
- `ADDR_WIDTH`, 10, instruction memory word-address width.

- `CLK100MHZ`  in  1  system clock, rising edge.
- `SWITCH_RESET`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only when `rx_done` is high.
- `rx_done`  in  1  one-cycle pulse per received byte.
- `halt_in`  in  1  one-cycle pulse from the MIPS pipeline when the HALT instruction completes.
- `imem_wr_en`  out  1  one-cycle instruction memory write strobe.
- `imem_addr`  out  ADDR_WIDTH  instruction memory word address.
- `imem_data`  out  LEN  assembled instruction word.
- `mips_clk_en`  out  1  MIPS pipeline advance enable.
- `mips_reset`  out  1  holds MIPS PC and pipeline in reset.
- `run_done`  out  1  high while in DONE.
- `state_out`  out  3  current state encoding, for LEDs and debug.

## Operation
- Command bytes: Start=0x01, Continuous=0x02, StepByStep=0x03, ReProgram=0x05, Step=0x06. In command-accepting states, any other byte is ignored.
- IDLE (code 0):
  - `mips_reset`=1, `mips_clk_en`=0.
  - 0x01 → PROGRAM, with `imem_addr`:=0 and byte counter:=0.
- PROGRAM (code 1):
  - Every byte is raw data and is never decoded as a command.
  - The byte counter goes 0..3. Bytes land in word bits [7:0], [15:8], [23:16], [31:24], in that order.
  - On the 4th byte, the assembled word is driven on `imem_data` with `imem_wr_en`=1 for one cycle at the current `imem_addr`. The address then increments and the counter clears.
  - If the word has bits [31:26]=6'b111111 (HALT), the next state is WAIT_MODE; otherwise the state stays PROGRAM.
  - The address wraps modulo 2^ADDR_WIDTH.
- WAIT_MODE (code 2):
  - `mips_reset`=1.
  - 0x02 → RUN_CONT. 0x03 → STEP_WAIT. 0x05 → IDLE.
- RUN_CONT (code 3):
  - `mips_reset`=0, `mips_clk_en`=1.
  - `halt_in` → DONE.
  - Bytes received in this state are ignored.
- STEP_WAIT (code 4):
  - `mips_reset`=0, `mips_clk_en`=0.
  - 0x06 → exactly one cycle of `mips_clk_en`=1; the state stays STEP_WAIT.
  - `halt_in` → DONE.
  - 0x05 → IDLE.
- DONE (code 5):
  - `mips_clk_en`=0, `mips_reset`=0 (register state is preserved for readout), `run_done`=1.
  - 0x05 → IDLE.
- Entering IDLE by any path clears the address, the counter and the partial word.

## Timing
- All outputs are registered.
- Reset values: `imem_wr_en`=0, `imem_addr`=0, `imem_data`=0, `mips_clk_en`=0, `mips_reset`=1, `run_done`=0, `state_out`=0.
- Write latency: `imem_wr_en` is high in the cycle after the `rx_done` of the 4th byte. `imem_addr` holds the write address during that cycle and increments on the following edge.
- Mode entry: `mips_clk_en` rises in the cycle after the `rx_done` carrying 0x02. `mips_reset` falls in the same cycle.
- Step: the `mips_clk_en` pulse occurs in the cycle after the `rx_done` carrying 0x06.
- Halt: `mips_clk_en` is 0 in the cycle after the `halt_in` cycle, and `run_done` rises in that same cycle.
- Simultaneous events:
  - `halt_in` together with `rx_done`=0x06 in STEP_WAIT: halt wins and no step pulse is issued.
  - `halt_in` in IDLE, PROGRAM, WAIT_MODE or DONE is ignored.
- Reset mid-operation, including mid-word: all state returns to IDLE and reset values. Partially assembled bytes are discarded; no write is issued.
- Back-to-back `rx_done` on consecutive cycles must be accepted with no byte lost.

## Test plan
- Single word: 0x01, then 0x24, 0x00, 0x08, 0x20 → one `imem_wr_en` pulse with `imem_data`=0x20080024 at addr 0; state stays PROGRAM; addr becomes 1.
- Program and run continuously:
  - Load two words, then 0xFC000000 → three writes at addrs 0, 1, 2; state WAIT_MODE.
  - Send 0x02 → `mips_clk_en`=1 and `mips_reset`=0 next cycle.
  - Pulse `halt_in` → `mips_clk_en`=0 and `run_done`=1 the next cycle.
- Step mode: after HALT load, send 0x03 and then three 0x06 bytes → exactly three single-cycle `mips_clk_en` pulses. Then `halt_in` → DONE. Then 0x05 → IDLE with `mips_reset`=1 and addr 0.
- Data bytes equal to command codes: send the word 0x05060201 in PROGRAM → written as data; no mode change.
- Reset after 2 of 4 bytes → no write; IDLE. A following 0x01 plus 4 bytes writes at addr 0 with only the new bytes.
- Wrap: with `ADDR_WIDTH`=2, load 5 non-HALT words → the 5th write goes to addr 0.
